// File: rtl/pipe_stage_hs_reg.sv
// rtl/pipe_stage_hs_reg.sv - valid/ready pipeline-stage register with flush and stall counter
// Optional 2-entry skid operation is enabled by defining PIPE_STAGE_SKID_EN.
module pipe_stage_hs_reg #(
   parameter int WIDTH = 160,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             r_main_valid;
   logic [WIDTH-1:0] r_main_data;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_stall;

   assign out_valid  = r_main_valid;
   assign out_data   = r_main_data;
   assign stall_cnt  = r_stall_cnt;
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = r_main_valid && out_ready;
   assign w_stall    = r_main_valid && !out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic             r_skid_valid;
   logic [WIDTH-1:0] r_skid_data;

   // Ready comes only from a register, breaking the out_ready -> in_ready path.
   assign in_ready = !r_skid_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_main_valid <= 1'b0;
         r_main_data  <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_out_xfer && r_skid_valid) begin
         r_main_data  <= r_skid_data;
         r_skid_valid <= 1'b0;
      end else if (w_in_xfer && r_main_valid && !w_out_xfer) begin
         r_skid_data  <= in_data;
         r_skid_valid <= 1'b1;
      end else if (w_in_xfer) begin
         r_main_data  <= in_data;
         r_main_valid <= 1'b1;
      end else if (w_out_xfer) begin
         r_main_valid <= 1'b0;
      end
   end
`else
   assign in_ready = !r_main_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_main_valid <= 1'b0;
         r_main_data  <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
      end else if (w_in_xfer) begin
         r_main_data  <= in_data;
         r_main_valid <= 1'b1;
      end else if (w_out_xfer) begin
         r_main_valid <= 1'b0;
      end
   end
`endif

   // Saturating: once all-ones, the counter stays there until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_hs_reg.sv
// tb/tb_pipe_stage_hs_reg.sv - self-checking bench for pipe_stage_hs_reg
// Builds for either setting of PIPE_STAGE_SKID_EN.
module tb_pipe_stage_hs_reg;
   localparam int W  = 16;
   localparam int CW = 3;
   localparam int CNT_MAX = (1 << CW) - 1;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  in_data, out_data;
   logic [CW-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_hs_reg #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic         rst, fl, iv;
      logic [W-1:0] d;
      logic         ordy;
      logic         ov;
      logic [W-1:0] od;
      int           st;
      int           rdy;   // 2 = 1 with skid, 0 without
   } vec_t;

   vec_t tbl[$];

   // Reference model: an ordered queue with capacity 1 (or 2 with skid).
   logic [W-1:0] m_q[$];
   logic [W-1:0] m_last;
   int           m_cnt;

   function automatic vec_t mk(logic r, logic f, logic iv, logic [W-1:0] d, logic o,
                               logic ov, logic [W-1:0] od, int st, int rdy);
      vec_t v;
      v.rst = r; v.fl = f; v.iv = iv; v.d = d; v.ordy = o;
      v.ov = ov; v.od = od; v.st = st; v.rdy = rdy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic iv,
                        input logic [W-1:0] d, input logic o);
      rst = r; flush = f; in_valid = iv; in_data = d; out_ready = o;
   endtask

   task automatic step(input logic r, input logic f, input logic iv,
                       input logic [W-1:0] d, input logic o);
      drive(r, f, iv, d, o);
      @(posedge clk);
      #1;
   endtask

   function automatic logic m_ov();
      return m_q.size() > 0;
   endfunction

   function automatic logic [W-1:0] m_od();
      return (m_q.size() > 0) ? m_q[0] : m_last;
   endfunction

   function automatic logic m_rdy(logic o);
      if (SKID) return m_q.size() < 2;
      return (m_q.size() == 0) || o;
   endfunction

   task automatic m_update(input logic r, input logic f, input logic iv,
                           input logic [W-1:0] d, input logic o);
      logic inx, outx;
      if (r) begin
         m_q.delete();
         m_last = '0;
         m_cnt  = 0;
      end else begin
         inx  = iv && m_rdy(o);
         outx = m_ov() && o;
         if (m_ov() && !o && m_cnt < CNT_MAX) m_cnt++;
         m_last = m_od();
         if (f) begin
            m_q.delete();
         end else begin
            if (outx) void'(m_q.pop_front());
            if (inx) m_q.push_back(d);
         end
      end
   endtask

   initial begin
      logic r, f, iv, o;
      logic [W-1:0] d;

      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);

      // Reset, streaming, backpressure, flush, saturation, reset.
      tbl.push_back(mk(1,0,0,16'h0000,0, 0,16'h0000,0,1));
      tbl.push_back(mk(1,0,0,16'h0000,0, 0,16'h0000,0,1));
      tbl.push_back(mk(0,0,1,16'h0001,1, 1,16'h0001,0,1));
      tbl.push_back(mk(0,0,1,16'h0002,1, 1,16'h0002,0,1));
      tbl.push_back(mk(0,0,1,16'h0003,1, 1,16'h0003,0,1));
      tbl.push_back(mk(0,0,1,16'h0004,1, 1,16'h0004,0,1));
      tbl.push_back(mk(0,0,0,16'h0000,1, 0,16'h0004,0,1));
      tbl.push_back(mk(0,0,1,16'h000A,0, 1,16'h000A,0,2));
      for (int i = 1; i <= 5; i++)
         tbl.push_back(mk(0,0,0,16'h0000,0, 1,16'h000A,i,2));
      tbl.push_back(mk(0,0,0,16'h0000,1, 0,16'h000A,5,1));
      tbl.push_back(mk(0,0,1,16'h0011,0, 1,16'h0011,5,2));
      tbl.push_back(mk(0,1,1,16'h000C,1, 0,16'h0011,5,1));
      tbl.push_back(mk(0,0,0,16'h0000,1, 0,16'h0011,5,1));
      tbl.push_back(mk(0,0,1,16'h0022,0, 1,16'h0022,5,2));
      tbl.push_back(mk(0,0,0,16'h0000,0, 1,16'h0022,6,2));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(0,0,0,16'h0000,0, 1,16'h0022,7,2));
      tbl.push_back(mk(1,0,0,16'h0000,0, 0,16'h0000,0,1));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
         chk($sformatf("vec%0d.out_valid", i), out_valid, tbl[i].ov);
         chk($sformatf("vec%0d.out_data", i), out_data, tbl[i].od);
         chk($sformatf("vec%0d.stall_cnt", i), stall_cnt, tbl[i].st);
         chk($sformatf("vec%0d.in_ready", i), in_ready,
             (tbl[i].rdy == 2) ? SKID : tbl[i].rdy);
      end

      // Second payload under backpressure: skid takes it, plain stage refuses it.
      step(1, 0, 0, '0, 0);
      step(0, 0, 1, 16'h00A1, 0);
      drive(0, 0, 1, 16'h00B2, 0);
      #1;
      chk("bp.in_ready_b", in_ready, SKID);
      @(posedge clk); #1;
      chk("bp.in_ready_full", in_ready, 1'b0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 0);
      chk("bp.hold_data", out_data, 16'h00A1);
      chk("bp.stall5", stall_cnt, 5);
      step(0, 0, 0, '0, 1);
      chk("bp.rel1_valid", out_valid, SKID);
      chk("bp.rel1_data", out_data, SKID ? 16'h00B2 : 16'h00A1);
      step(0, 0, 0, '0, 1);
      chk("bp.rel2_valid", out_valid, 1'b0);

      // Reset in the middle of a stall with every entry occupied.
      step(0, 0, 1, 16'h00C3, 0);
      step(0, 0, 1, 16'h00D4, 0);
      step(0, 0, 0, '0, 0);
      step(1, 0, 0, '0, 0);
      chk("rst_mid.out_valid", out_valid, 1'b0);
      chk("rst_mid.stall_cnt", stall_cnt, 0);
      chk("rst_mid.in_ready", in_ready, 1'b1);
      step(0, 0, 0, '0, 1);
      chk("rst_mid.no_ghost", out_valid, 1'b0);

      // Randomised traffic against the queue model.
      step(1, 0, 0, '0, 0);
      m_update(1, 0, 0, '0, 0);
      for (int c = 0; c < 3000; c++) begin
         r  = ($urandom_range(0, 99) == 0);
         f  = ($urandom_range(0, 19) == 0);
         iv = ($urandom_range(0, 99) < 60);
         o  = ($urandom_range(0, 99) < 55);
         d  = W'($urandom);
         drive(r, f, iv, d, o);
         #1;
         chk("rnd.in_ready", in_ready, m_rdy(o));
         chk("rnd.out_valid", out_valid, m_ov());
         chk("rnd.out_data", out_data, m_od());
         chk("rnd.stall_cnt", stall_cnt, m_cnt);
         @(posedge clk);
         m_update(r, f, iv, d, o);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
